// File: rtl/lsu_mem_stage_if.sv
// Data memory bus between the MEM-stage load/store unit and the memory.
// Latency: none, wires only.
// Backpressure: the memory holds off completion by keeping bus_ready low.
interface lsu_mem_stage_if #(
  parameter int WIDTH_DATA = 32,
  parameter int WIDTH_ADDR = 32
);
  logic                  bus_req;
  logic                  bus_we;
  logic [WIDTH_ADDR-1:0] bus_addr;
  logic [3:0]            bus_wstrb;
  logic [WIDTH_DATA-1:0] bus_wdata;
  logic                  bus_ready;
  logic [WIDTH_DATA-1:0] bus_rdata;

  // The load/store unit issues requests.
  modport master (
    output bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
    input  bus_ready, bus_rdata
  );

  // The memory answers them.
  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
    output bus_ready, bus_rdata
  );
endinterface

// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store unit: RV32I load/store to word-aligned strobed bus access, load extension.
// Latency: stall is k+1 cycles for a bus answering in cycle k (minimum 2), then one DONE cycle.
// Backpressure: M_Stall holds IF..MEM while the bus is busy; LSU_MISALIGN_TRAP_EN traps misaligned accesses.
module lsu_mem_stage #(
  parameter int WIDTH_DATA = 32,
  parameter int WIDTH_ADDR = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  M_MemRead,
  input  logic                  M_MemWrite,
  input  logic [2:0]            M_funct3,
  input  logic [WIDTH_ADDR-1:0] M_Addr,
  input  logic [WIDTH_DATA-1:0] M_WriteData,
  output logic [WIDTH_DATA-1:0] M_ReadData,
  output logic                  M_Stall,
  output logic                  M_Misaligned,
  lsu_mem_stage_if.master       bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                state_q, state_d;
  logic                  access;
  logic                  misaligned;
  logic                  issue;
  logic [WIDTH_ADDR-1:0] addr_q;
  logic                  we_q;
  logic [3:0]            wstrb_q, wstrb_d;
  logic [WIDTH_DATA-1:0] wdata_q, wdata_d;
  logic [2:0]            funct3_q;
  logic [1:0]            lane_q;
  logic [7:0]            lane_byte;
  logic [15:0]           lane_half;
  logic [WIDTH_DATA-1:0] load_ext;

  // A store wins when both requests are raised together.
  assign access = M_MemRead | M_MemWrite;

`ifdef LSU_MISALIGN_TRAP_EN
  logic trap;
  logic misaligned_q;

  // Halfwords must sit on an even address, words (and undefined sizes) on a word boundary.
  always_comb begin
    misaligned = 1'b0;
    case (M_funct3[1:0])
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = M_Addr[0];
      default: misaligned = |M_Addr[1:0];
    endcase
  end

  assign trap = (state_q == IDLE) && access && misaligned;

  // One-cycle registered pulse in the cycle after a trapped access.
  always_ff @(posedge clk) begin
    if (rst) misaligned_q <= 1'b0;
    else     misaligned_q <= trap;
  end

  assign M_Misaligned = misaligned_q;
`else
  // Low address bits beyond the access size are simply ignored.
  assign misaligned   = 1'b0;
  assign M_Misaligned = 1'b0;
`endif

  // Store lane placement: replicate the datum, strobe only the addressed bytes.
  always_comb begin
    wstrb_d = 4'b1111;
    wdata_d = M_WriteData;
    case (M_funct3[1:0])
      2'b00: begin
        wstrb_d = 4'b0001 << M_Addr[1:0];
        wdata_d = {4{M_WriteData[7:0]}};
      end
      2'b01: begin
        wstrb_d = M_Addr[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{M_WriteData[15:0]}};
      end
      default: begin
        wstrb_d = 4'b1111;
        wdata_d = M_WriteData;
      end
    endcase
    if (!M_MemWrite) wstrb_d = 4'b0000;
  end

  // Next state and stall; stall is combinational so the access cycle itself is held.
  always_comb begin
    state_d = state_q;
    M_Stall = 1'b0;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (access && !misaligned) begin
          issue   = 1'b1;
          M_Stall = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        M_Stall = 1'b1;
        if (bus.bus_ready) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (rst) M_Stall = 1'b0;
  end

  // State register; reset abandons any outstanding bus response.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Request capture; the bus fields stay frozen until the next access is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      we_q     <= 1'b0;
      wstrb_q  <= 4'b0000;
      wdata_q  <= '0;
      funct3_q <= 3'b000;
      lane_q   <= 2'b00;
    end else if (issue) begin
      addr_q   <= {M_Addr[WIDTH_ADDR-1:2], 2'b00};
      we_q     <= M_MemWrite;
      wstrb_q  <= wstrb_d;
      wdata_q  <= wdata_d;
      funct3_q <= M_funct3;
      lane_q   <= M_Addr[1:0];
    end
  end

  // Lane extraction and sign/zero extension of the returned word.
  always_comb begin
    lane_byte = bus.bus_rdata[{lane_q, 3'b000} +: 8];
    lane_half = lane_q[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
    case (funct3_q[1:0])
      2'b00:   load_ext = funct3_q[2] ? {24'h000000, lane_byte}
                                      : {{24{lane_byte[7]}}, lane_byte};
      2'b01:   load_ext = funct3_q[2] ? {16'h0000, lane_half}
                                      : {{16{lane_half[15]}}, lane_half};
      default: load_ext = bus.bus_rdata;
    endcase
  end

  // Load result register; read data is only trusted while requesting and ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      M_ReadData <= '0;
    end else if ((state_q == BUSY) && bus.bus_ready && !we_q) begin
      M_ReadData <= load_ext;
`ifdef LSU_MISALIGN_TRAP_EN
    end else if (trap && !M_MemWrite) begin
      M_ReadData <= '0;
`endif
    end
  end

  assign bus.bus_req   = (state_q == BUSY);
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wstrb = wstrb_q;
  assign bus.bus_wdata = wdata_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Bench for lsu_mem_stage: directed cases plus randomized accesses against an arithmetic model.
// Inputs are driven at the falling edge; outputs are sampled 1 time unit later.
// Honours LSU_MISALIGN_TRAP_EN when compiled with it.
module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        M_MemRead, M_MemWrite;
  logic [2:0]  M_funct3;
  logic [31:0] M_Addr, M_WriteData;
  logic [31:0] M_ReadData;
  logic        M_Stall, M_Misaligned;

  lsu_mem_stage_if mem ();

  lsu_mem_stage dut (
    .clk(clk), .rst(rst),
    .M_MemRead(M_MemRead), .M_MemWrite(M_MemWrite), .M_funct3(M_funct3),
    .M_Addr(M_Addr), .M_WriteData(M_WriteData), .M_ReadData(M_ReadData),
    .M_Stall(M_Stall), .M_Misaligned(M_Misaligned), .bus(mem)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [31:0] model_rd;

  // Observations from the last run_access call.
  int          obs_stall, obs_req;
  logic [31:0] obs_addr, obs_wdata, obs_rd;
  logic [3:0]  obs_strb;
  logic        obs_we, obs_stable, obs_done, obs_mis;

  // ---- reference model: plain arithmetic from the access rules ----
  function automatic int unsigned acc_size(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic int unsigned acc_off(input logic [2:0] f3, input logic [31:0] a);
    int unsigned s = acc_size(f3);
    if (s == 1) return a % 4;
    if (s == 2) return ((a % 4) / 2) * 2;
    return 0;
  endfunction

  function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [31:0] a);
    int unsigned s = acc_size(f3);
    return 4'(((1 << s) - 1) << acc_off(f3, a));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    int unsigned s = acc_size(f3);
    longint unsigned v = longint'(d) & ((64'd1 << (s * 8)) - 1);
    if (s == 1) return 32'(v * 64'h01010101);
    if (s == 2) return 32'(v * 64'h00010001);
    return 32'(v);
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    int unsigned s = acc_size(f3);
    longint v = (longint'(w) >> (acc_off(f3, a) * 8)) & ((64'sd1 << (s * 8)) - 1);
    if (!f3[2] && s < 4 && v >= (64'sd1 << (s * 8 - 1))) v = v - (64'sd1 << (s * 8));
    return 32'(v);
  endfunction

  // Drive one access; bus_ready first rises in cycle k (held from cycle 0 when k == 1).
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd,
                            input int k, input logic [31:0] rword);
    logic first = 1'b1;
    obs_stall = 0; obs_req = 0; obs_stable = 1'b1; obs_done = 1'b0; obs_mis = 1'b0;
    obs_addr = '0; obs_strb = '0; obs_wdata = '0; obs_we = 1'b0; obs_rd = '0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      M_MemRead = rd; M_MemWrite = wr; M_funct3 = f3; M_Addr = a; M_WriteData = wd;
      mem.bus_ready = (c >= k) || (k == 1);
      mem.bus_rdata = mem.bus_ready ? rword : $urandom;
      #1;
      if (M_Misaligned) obs_mis = 1'b1;
      if (M_Stall) obs_stall++;
      if (mem.bus_req) begin
        obs_req++;
        if (first) begin
          obs_addr = mem.bus_addr; obs_strb = mem.bus_wstrb;
          obs_wdata = mem.bus_wdata; obs_we = mem.bus_we;
        end else if (obs_addr !== mem.bus_addr || obs_strb !== mem.bus_wstrb ||
                     obs_wdata !== mem.bus_wdata || obs_we !== mem.bus_we) begin
          obs_stable = 1'b0;
        end
        first = 1'b0;
      end
      if (c > 0 && !M_Stall) begin
        obs_done = 1'b1;
        obs_rd = M_ReadData;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    M_MemRead = 1'b1; M_Addr = 32'h40; mem.bus_ready = 1'b1;
    #1;
    tests++; if (M_Stall !== 1'b0) begin fails++; $display("FAIL reset_stall got %b want 0", M_Stall); end
    tests++; if (mem.bus_req !== 1'b0) begin fails++; $display("FAIL reset_req got %b want 0", mem.bus_req); end
    tests++; if ({mem.bus_we, mem.bus_addr, mem.bus_wstrb, mem.bus_wdata} !== '0) begin
      fails++; $display("FAIL reset_bus got we=%b addr=%h strb=%b wdata=%h want all 0",
                        mem.bus_we, mem.bus_addr, mem.bus_wstrb, mem.bus_wdata); end
    tests++; if (M_ReadData !== 32'h0) begin fails++; $display("FAIL reset_rdata got %h want 0", M_ReadData); end
    tests++; if (M_Misaligned !== 1'b0) begin fails++; $display("FAIL reset_mis got %b want 0", M_Misaligned); end
    @(negedge clk);
    rst = 1'b0; M_MemRead = 1'b0; mem.bus_ready = 1'b0;
    #1;
    tests++; if (M_Stall !== 1'b0 || mem.bus_req !== 1'b0) begin
      fails++; $display("FAIL idle_after_reset got stall=%b req=%b want 0 0", M_Stall, mem.bus_req); end
    model_rd = 32'h0;
  endtask

  task automatic test_sw();
    run_access(1'b0, 1'b1, 3'b010, 32'h0000_0104, 32'hDEADBEEF, 1, 32'h0);
    tests++; if (!obs_done) begin fails++; $display("FAIL sw_done got timeout want DONE"); end
    tests++; if (obs_addr !== 32'h104 || obs_strb !== 4'b1111 || obs_wdata !== 32'hDEADBEEF || obs_we !== 1'b1) begin
      fails++; $display("FAIL sw_bus got addr=%h strb=%b wdata=%h we=%b want 104 1111 deadbeef 1",
                        obs_addr, obs_strb, obs_wdata, obs_we); end
    tests++; if (obs_stall != 2 || obs_req != 1) begin
      fails++; $display("FAIL sw_timing got stall=%0d req=%0d want 2 1", obs_stall, obs_req); end
  endtask

  task automatic test_sb();
    run_access(1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 2, 32'h0);
    tests++; if (obs_addr !== 32'h100 || obs_strb !== 4'b1000 || obs_wdata !== 32'hA5A5A5A5 || obs_we !== 1'b1) begin
      fails++; $display("FAIL sb_bus got addr=%h strb=%b wdata=%h we=%b want 100 1000 a5a5a5a5 1",
                        obs_addr, obs_strb, obs_wdata, obs_we); end
    tests++; if (M_ReadData !== model_rd) begin
      fails++; $display("FAIL sb_rdata_hold got %h want %h", M_ReadData, model_rd); end
  endtask

  // LB immediately followed by LBU: also covers back-to-back issue after DONE.
  task automatic test_back_to_back();
    run_access(1'b1, 1'b0, 3'b000, 32'h0000_0102, 32'h0, 3, 32'h1280_3456);
    tests++; if (obs_rd !== 32'hFFFF_FF80 || obs_stall != 4 || obs_req != 3) begin
      fails++; $display("FAIL lb got rdata=%h stall=%0d req=%0d want ffffff80 4 3", obs_rd, obs_stall, obs_req); end
    tests++; if (obs_strb !== 4'b0000 || obs_we !== 1'b0 || obs_addr !== 32'h100) begin
      fails++; $display("FAIL lb_bus got strb=%b we=%b addr=%h want 0000 0 100", obs_strb, obs_we, obs_addr); end
    run_access(1'b1, 1'b0, 3'b100, 32'h0000_0102, 32'h0, 3, 32'h1280_3456);
    tests++; if (obs_rd !== 32'h0000_0080 || obs_stall != 4) begin
      fails++; $display("FAIL lbu got rdata=%h stall=%0d want 00000080 4", obs_rd, obs_stall); end
    run_access(1'b1, 1'b0, 3'b001, 32'h0000_0202, 32'h0, 2, 32'h8001_0000);
    tests++; if (obs_rd !== 32'hFFFF_8001 || obs_addr !== 32'h200) begin
      fails++; $display("FAIL lh got rdata=%h addr=%h want ffff8001 200", obs_rd, obs_addr); end
    model_rd = 32'hFFFF_8001;
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      int sel = $urandom_range(0, 2);
      logic rd = (sel != 1);
      logic wr = (sel != 0);
      logic [2:0] f3 = 3'($urandom_range(0, 7));
      logic [31:0] a = $urandom;
      logic [31:0] wd = $urandom;
      logic [31:0] rw = $urandom;
      int k = $urandom_range(1, 4);
`ifdef LSU_MISALIGN_TRAP_EN
      a = a & ~32'(acc_size(f3) - 1);
`endif
      run_access(rd, wr, f3, a, wd, k, rw);
      if (!wr) model_rd = m_load(f3, a, rw);
      tests++; if (!obs_done || obs_stall != k + 1 || obs_req != k || !obs_stable) begin
        fails++; $display("FAIL rnd%0d_timing got done=%b stall=%0d req=%0d stable=%b want 1 %0d %0d 1",
                          i, obs_done, obs_stall, obs_req, obs_stable, k + 1, k); end
      tests++; if (obs_addr !== {a[31:2], 2'b00} || obs_we !== wr) begin
        fails++; $display("FAIL rnd%0d_addr got addr=%h we=%b want %h %b", i, obs_addr, obs_we, {a[31:2], 2'b00}, wr); end
      tests++; if (obs_strb !== (wr ? m_strb(f3, a) : 4'b0000)) begin
        fails++; $display("FAIL rnd%0d_strb got %b want %b", i, obs_strb, wr ? m_strb(f3, a) : 4'b0000); end
      if (wr) begin
        tests++; if (obs_wdata !== m_wdata(f3, wd)) begin
          fails++; $display("FAIL rnd%0d_wdata got %h want %h", i, obs_wdata, m_wdata(f3, wd)); end
      end
      tests++; if (obs_rd !== model_rd || obs_mis !== 1'b0) begin
        fails++; $display("FAIL rnd%0d_rdata got %h mis=%b want %h 0", i, obs_rd, obs_mis, model_rd); end
    end
  endtask

  task automatic test_misalign();
`ifdef LSU_MISALIGN_TRAP_EN
    @(negedge clk);
    M_MemRead = 1'b1; M_MemWrite = 1'b0; M_funct3 = 3'b010; M_Addr = 32'h0000_0106;
    mem.bus_ready = 1'b1;
    #1;
    tests++; if (M_Stall !== 1'b0 || mem.bus_req !== 1'b0) begin
      fails++; $display("FAIL mis_lw_c0 got stall=%b req=%b want 0 0", M_Stall, mem.bus_req); end
    @(negedge clk);
    M_MemRead = 1'b0;
    #1;
    tests++; if (M_Misaligned !== 1'b1 || mem.bus_req !== 1'b0 || M_ReadData !== 32'h0) begin
      fails++; $display("FAIL mis_lw_c1 got mis=%b req=%b rdata=%h want 1 0 0", M_Misaligned, mem.bus_req, M_ReadData); end
    @(negedge clk);
    M_MemWrite = 1'b1; M_funct3 = 3'b001; M_Addr = 32'h0000_0101;
    #1;
    tests++; if (M_Misaligned !== 1'b0 || M_Stall !== 1'b0) begin
      fails++; $display("FAIL mis_pulse_end got mis=%b stall=%b want 0 0", M_Misaligned, M_Stall); end
    @(negedge clk);
    M_MemWrite = 1'b0;
    #1;
    tests++; if (M_Misaligned !== 1'b1 || mem.bus_req !== 1'b0) begin
      fails++; $display("FAIL mis_sh got mis=%b req=%b want 1 0", M_Misaligned, mem.bus_req); end
    model_rd = 32'h0;
`else
    run_access(1'b1, 1'b0, 3'b010, 32'h0000_0106, 32'h0, 1, 32'hCAFE_F00D);
    tests++; if (obs_addr !== 32'h104 || obs_rd !== 32'hCAFE_F00D || obs_mis !== 1'b0 || obs_stall != 2) begin
      fails++; $display("FAIL unal_lw got addr=%h rdata=%h mis=%b stall=%0d want 104 cafef00d 0 2",
                        obs_addr, obs_rd, obs_mis, obs_stall); end
    run_access(1'b0, 1'b1, 3'b001, 32'h0000_0103, 32'h0000_BEEF, 2, 32'h0);
    tests++; if (obs_strb !== 4'b1100 || obs_wdata !== 32'hBEEF_BEEF || obs_mis !== 1'b0) begin
      fails++; $display("FAIL unal_sh got strb=%b wdata=%h mis=%b want 1100 beefbeef 0", obs_strb, obs_wdata, obs_mis); end
    model_rd = 32'hCAFE_F00D;
`endif
  endtask

  task automatic test_reset_busy();
    @(negedge clk);
    M_MemRead = 1'b1; M_MemWrite = 1'b0; M_funct3 = 3'b010; M_Addr = 32'h0000_0300;
    mem.bus_ready = 1'b0;
    @(negedge clk);
    #1;
    tests++; if (mem.bus_req !== 1'b1 || M_Stall !== 1'b1) begin
      fails++; $display("FAIL rb_busy got req=%b stall=%b want 1 1", mem.bus_req, M_Stall); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests++; if (M_Stall !== 1'b0) begin fails++; $display("FAIL rb_stall_in_reset got %b want 0", M_Stall); end
    @(negedge clk);
    #1;
    tests++; if (mem.bus_req !== 1'b0 || M_ReadData !== 32'h0) begin
      fails++; $display("FAIL rb_after_edge got req=%b rdata=%h want 0 0", mem.bus_req, M_ReadData); end
    @(negedge clk);
    rst = 1'b0; M_MemRead = 1'b0; mem.bus_ready = 1'b1;
    @(negedge clk);
    #1;
    tests++; if (mem.bus_req !== 1'b0 || M_Stall !== 1'b0) begin
      fails++; $display("FAIL rb_idle got req=%b stall=%b want 0 0", mem.bus_req, M_Stall); end
    run_access(1'b0, 1'b1, 3'b010, 32'h0000_0010, 32'h1234_5678, 1, 32'h0);
    tests++; if (obs_stall != 2 || obs_req != 1 || obs_wdata !== 32'h1234_5678) begin
      fails++; $display("FAIL rb_recover got stall=%0d req=%0d wdata=%h want 2 1 12345678", obs_stall, obs_req, obs_wdata); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; M_MemRead = 1'b0; M_MemWrite = 1'b0; M_funct3 = 3'b000;
    M_Addr = '0; M_WriteData = '0; mem.bus_ready = 1'b0; mem.bus_rdata = '0;
    model_rd = '0;
    repeat (3) @(posedge clk);
    test_reset();
    test_sw();
    test_sb();
    test_back_to_back();
    test_random();
    test_misalign();
    test_reset_busy();
    @(negedge clk);
    M_MemRead = 1'b0; M_MemWrite = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lsu_mem_stage.md
# lsu_mem_stage

Load/store unit for the MEM stage of the pipelined RV32I core. It sits between the EX/MEM pipeline register and the data memory bus. It converts a MEM-stage load or store into a word-aligned bus transaction with byte strobes, and holds the pipeline with a stall request until the bus completes. It then sign- or zero-extends load data and presents it to the MEM/WB register.

## Interface
- WIDTH_DATA, 32: data width; the block supports only 32.
- WIDTH_ADDR, 32: address width.

- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- M_MemRead  input  1  load request from the MEM stage.
- M_MemWrite  input  1  store request from the MEM stage.
- M_funct3  input  3  access size and signedness (RV32I encoding).
- M_Addr  input  WIDTH_ADDR  byte address (the ALU result).
- M_WriteData  input  WIDTH_DATA  store data; the used bits are right-aligned.
- M_ReadData  output  WIDTH_DATA  extended load data.
- M_Stall  output  1  stall request to the hazard unit; freezes IF through MEM.
- M_Misaligned  output  1  one-cycle pulse flagging a misaligned access.
- bus_req  output  1  bus request.
- bus_we  output  1  1 = write.
- bus_addr  output  WIDTH_ADDR  word-aligned address; bits [1:0] are always 0.
- bus_wstrb  output  4  byte write strobes.
- bus_wdata  output  WIDTH_DATA  lane-aligned write data.
- bus_ready  input  1  bus completion; qualified by bus_req.
- bus_rdata  input  WIDTH_DATA  read word; valid in the bus_ready cycle.

## Operation
- The block is a state machine with three states: IDLE, BUSY and DONE.
- Access request: an access is requested when M_MemRead or M_MemWrite is 1. If both are 1, the access is a store.

**IDLE**
- On an aligned access request:
  - Register the bus address, bus_we, bus_wstrb, bus_wdata, funct3 and addr[1:0].
  - Go to BUSY.
  - M_Stall = 1 combinationally.
- No access request: stay in IDLE; M_Stall = 0.

**BUSY**
- bus_req = 1. All bus outputs stay stable until bus_ready.
- M_Stall = 1.
- On bus_ready:
  - For a load, capture bus_rdata, extract the addressed lane, extend it, and register the result into M_ReadData.
  - Go to DONE.

**DONE**
- M_Stall = 0 and bus_req = 0, so the pipeline advances at the end of this cycle.
- The request still present on the inputs is not re-issued.
- Always go to IDLE next.

**Store lanes**
- SB (000): wstrb = 0001 << addr[1:0]; the wdata byte is replicated to all 4 lanes.
- SH (001): wstrb = 0011 or 1100, selected by addr[1]; the wdata halfword is replicated.
- SW (010): wstrb = 1111.

**Load extension**
- LB (000): sign-extend the selected byte.
- LBU (100): zero-extend the selected byte.
- LH (001): sign-extend the selected halfword.
- LHU (101): zero-extend the selected halfword.
- LW (010): the full word.

**Other rules**
- Undefined funct3 (011, 110, 111): treated as a word access.
- On a load, bus_wstrb = 0000.
- M_ReadData holds its value until the next load completes.
- bus_ready while bus_req = 0 is ignored.

## Timing
- Reset values: state IDLE; bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata, M_ReadData and M_Misaligned are all 0. M_Stall is 0 during reset.
- Reset asserted in BUSY or DONE: go to IDLE and drop bus_req on the next edge. An outstanding bus response is discarded.
- Latency, with the request first seen in cycle 0 and bus_ready first in cycle k ≥ 1:
  - bus_req is high in cycles 1..k.
  - DONE is cycle k+1.
  - M_Stall is high in cycles 0..k.
  - Stall cycles = k+1; the minimum is 2.
- Zero-wait bus (bus_ready held at 1): the bus completes in cycle 1 and the block is in DONE at cycle 2.
- Back-to-back accesses: the next access is recognised in the cycle after DONE. There is no gap beyond the FSM cycles.
- bus_rdata is sampled only in a cycle where bus_req and bus_ready are both 1.

## Configuration
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - A halfword access with addr[0] = 1, or a word access with addr[1:0] ≠ 00, issues no bus transaction.
  - M_Misaligned pulses for exactly one cycle (registered, in the cycle after detection), and the FSM stays in IDLE.
  - A misaligned store writes nothing. A misaligned load returns M_ReadData = 0.
  - M_Stall = 0 for a misaligned access.
- Not defined:
  - M_Misaligned is tied to 0.
  - The misaligned address bits are ignored: halfword accesses use addr[1], word accesses use lane 0. No access is suppressed.

## Test plan
- SW to 0x0000_0104 with data 0xDEADBEEF, bus_ready held at 1 → bus_addr 0x104, wstrb 1111, wdata 0xDEADBEEF; M_Stall high for exactly 2 cycles.
- SB to 0x0000_0103 with data 0x0000_00A5 → wstrb 1000, wdata 0xA5A5A5A5, bus_we 1.
- LB then LBU from 0x0000_0102, with bus_rdata 0x1280_3456 and bus_ready delayed 3 cycles → M_ReadData 0xFFFF_FF80 (LB) and 0x0000_0080 (LBU); M_Stall high for 4 cycles each.
- LH from 0x0000_0202, with bus_rdata 0x8001_0000 → M_ReadData 0xFFFF_8001.
- rst asserted while in BUSY, with bus_ready never arriving → bus_req 0 and state IDLE after 1 edge; M_Stall 0; M_ReadData 0.
- LSU_MISALIGN_TRAP_EN defined, LW from 0x0000_0106 → no bus_req, M_Misaligned pulses for 1 cycle, M_Stall 0, M_ReadData 0.
